// File: rtl/ser_word_deser_if.sv
// rtl/ser_word_deser_if.sv - serial-bit input and parallel-word output bundle for ser_word_deser
//
// Purpose: groups the serial input stream and the word output handshake.
// Signals:
//   s_valid  serial bit valid this cycle (no back-pressure)
//   s_bit    serial data bit
//   s_sof    start-of-frame, qualified by s_valid
//   m_data   assembled N-bit word
//   m_valid  holding register full
//   m_ready  consumer accepts m_data
// Modports: slave = deserializer side, master = producer/consumer side.
interface ser_word_deser_if #(
  parameter int N = 8
);
  logic         s_valid;
  logic         s_bit;
  logic         s_sof;
  logic [N-1:0] m_data;
  logic         m_valid;
  logic         m_ready;

  modport slave (
    input  s_valid, s_bit, s_sof, m_ready,
    output m_data, m_valid
  );

  modport master (
    output s_valid, s_bit, s_sof, m_ready,
    input  m_data, m_valid
  );
endinterface

// File: rtl/ser_word_deser.sv
// rtl/ser_word_deser.sv - serial-to-parallel word assembler with one-word holding register
//
// Purpose: collects N serial bits into a word and offers it on a valid/ready
// port through a single holding register. Words completed while the holding
// register is full and not draining are dropped and recorded in a sticky ovf.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      ser_word_deser_if slave (s_valid/s_bit/s_sof in, m_data/m_valid out, m_ready in)
//   bit_cnt  bits already collected toward the current word
//   busy     a partial word is being collected
//   ovf      sticky overflow flag (word lost under back-pressure)
//   ovf_clr  synchronous clear of ovf; a same-cycle set takes priority
module ser_word_deser #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset_n,
  ser_word_deser_if.slave   bus,
  output logic [CW-1:0]     bit_cnt,
  output logic              busy,
  output logic              ovf,
  input  logic              ovf_clr
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;

  logic [N-1:0]  shifted;
  logic [N-1:0]  first;
  logic          complete;
  logic          drain;
  logic          drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    complete = 1'b0;
    drop     = 1'b0;
    drain    = valid_q & bus.m_ready;

    // shifted: accumulator with the incoming bit appended.
    // first: a fresh word holding only the incoming bit, so no stale bits
    // from a discarded partial word survive.
    if (MSB_FIRST) begin
      shifted = {acc_q[N-2:0], bus.s_bit};
      first   = {{(N-1){1'b0}}, bus.s_bit};
    end else begin
      shifted = {bus.s_bit, acc_q[N-1:1]};
      first   = {bus.s_bit, {(N-1){1'b0}}};
    end

    case (state_q)
      IDLE: begin
        if (bus.s_valid) begin
          acc_d   = first;
          cnt_d   = CW'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.s_valid) begin
          if (bus.s_sof) begin
            // Restart wins even over a would-be N-th bit.
            acc_d = first;
            cnt_d = CW'(1);
          end else if (cnt_q == CW'(N - 1)) begin
            acc_d    = shifted;
            cnt_d    = '0;
            state_d  = IDLE;
            complete = 1'b1;
          end else begin
            acc_d = shifted;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A completing word may load the holding register when it is empty or
    // draining in the same cycle; otherwise it is lost.
    if (complete) begin
      if (!valid_q || drain) begin
        data_d  = shifted;
        valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (drain) begin
      valid_d = 1'b0;
    end

    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  assign bus.m_data  = data_q;
  assign bus.m_valid = valid_q;
  assign bit_cnt     = cnt_q;
  assign busy        = (state_q == COLLECT);
  assign ovf         = ovf_q;

endmodule

// File: doc/ser_word_deser.md
Name: ser_word_deser

Overview:
Serial-to-parallel word assembler that sits directly downstream of the universal shift register. It consumes the serial bit stream taken from the register's shift-out end and assembles N-bit words. Completed words are presented on a valid/ready output port with a one-word holding register. A sticky overflow flag records words lost under backpressure.

Parameters:
N, 8, word width in bits (N >= 2)
MSB_FIRST, 1, 1: the first received bit lands in m_data[N-1]; 0: the first received bit lands in m_data[0]

Ports:
clk  input  1  clock; all flops on the rising edge
reset_n  input  1  asynchronous active-low reset
s_valid  input  1  s_bit is valid this cycle; no ready, every valid bit must be taken
s_bit  input  1  serial data bit
s_sof  input  1  start-of-frame; qualified by s_valid; this bit becomes bit 0 of a new word
m_data  output  N  assembled word, stable while m_valid=1
m_valid  output  1  holding register is full
m_ready  input  1  consumer accepts m_data when m_valid & m_ready
bit_cnt  output  $clog2(N)  bits already collected toward the current word
busy  output  1  state is COLLECT
ovf  output  1  sticky overflow flag
ovf_clr  input  1  synchronous clear of ovf

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, bit_cnt=0, shift accumulator=0, m_data=0, m_valid=0, ovf=0, busy=0. Takes effect immediately, mid-word or mid-handshake; any partial word and any held word are discarded.
- FSM states: IDLE (bit_cnt=0, no partial word) and COLLECT (1 <= bit_cnt <= N-1).
- IDLE + s_valid: accept the bit as bit 0, bit_cnt<=1, go to COLLECT. s_sof is irrelevant in IDLE.
- COLLECT + s_valid + !s_sof: accept the bit, bit_cnt<=bit_cnt+1.
- COLLECT + s_valid + s_sof: discard the partial word, accept the bit as bit 0, bit_cnt<=1, stay in COLLECT. No ovf.
- s_valid=0: no state change (gaps allowed anywhere).
- Bit placement:
  - MSB_FIRST=1: accumulator shifts left, new bit enters the LSB.
  - MSB_FIRST=0: accumulator shifts right, new bit enters the MSB.
  - After N bits, the first received bit sits at MSB or LSB respectively.
- Word completion: the cycle the N-th bit is accepted, the completed word (including that bit) is the candidate, bit_cnt<=0, state<=IDLE.
  - If m_valid=0, or (m_valid & m_ready) in the same cycle: m_data<=word and m_valid<=1 on that edge. Latency is one clock from the last bit's edge to m_valid visible.
  - Otherwise the word is dropped, m_data is unchanged, and ovf<=1.
- Completion with N-th bit & s_sof: s_sof wins. The partial word is discarded and no word is produced.
- Output handshake:
  - m_valid & m_ready with no completion that cycle: m_valid<=0, and m_data holds its last value.
  - m_valid must not drop without m_ready.
  - m_data must not change while m_valid=1 except on a same-cycle drain and reload.
- Throughput: with m_ready tied high, back-to-back words with no gaps are sustained (one word per N valid bits, zero dead cycles).
- ovf:
  - Set on any dropped word.
  - ovf_clr clears it.
  - If a set and ovf_clr occur in the same cycle, set wins (ovf=1).
- bit_cnt width: $clog2(N). It wraps to 0 on completion and never reaches N.

Test Plan:
- N=8, MSB_FIRST=1, m_ready=1; bits 1,0,1,1,0,0,1,0 on consecutive cycles -> m_data=8'hB2, m_valid=1 for one cycle, one clock after the 8th bit; ovf=0.
- Same bits with MSB_FIRST=0 -> m_data=8'h4D. Then 16 back-to-back bits forming 8'hA5 and 8'h3C -> two single-cycle m_valid pulses, 8 cycles apart, no ovf.
- m_ready=0; send 8'h11 then 8'h22 -> m_data holds 8'h11 and m_valid stays 1; ovf=1 after the 16th bit. Then m_ready=1 -> 8'h11 accepted and m_valid=0. Pulse ovf_clr -> ovf=0.
- Holding register full with m_ready asserted on the exact cycle the next word completes (8'h5A) -> m_data=8'h5A on the next edge, m_valid stays 1, ovf=0.
- After 5 bits, s_sof with bit 1, then 7 more bits (0,0,0,0,0,0,1) -> m_data=8'h81, with the earlier 5 bits absent. s_sof on an 8th bit -> no word, bit_cnt=1.
- Assert reset_n=0 mid-word (bit_cnt=3) and while m_valid=1, asynchronously between edges -> all outputs reset immediately. After release, a fresh 8 bits produce the correct word from bit 0.
